// File: rtl/serial_suber.sv
// Digit-serial borrow-ripple subtractor: D = A - B - Bin (mod 2^N), W bits per clock.
// Optional signed-overflow flag enabled by defining SUBER_OVF_EN.
module serial_suber #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         ovf
);

    localparam int K  = N / W;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a_r, b_r, res_r;
    logic          borrow;
    logic [IW-1:0] idx;

    logic [W-1:0]  dig;
    logic [W:0]    chain;
    logic [N-1:0]  res_next;
    logic          last;

    assign last = (idx == IW'(K - 1));

    // Shared W-bit ripple stage operating on the digit selected by idx
    always_comb begin
        chain    = '0;
        dig      = '0;
        chain[0] = borrow;
        for (int unsigned i = 0; i < W; i++) begin
            dig[i]     = a_r[idx*W + i] ^ b_r[idx*W + i] ^ chain[i];
            chain[i+1] = (~a_r[idx*W + i] & (b_r[idx*W + i] | chain[i]))
                       | (b_r[idx*W + i] & chain[i]);
        end
        res_next             = res_r;
        res_next[idx*W +: W] = dig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            borrow <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r    <= A;
                        b_r    <= B;
                        borrow <= Bin;
                        res_r  <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    res_r  <= res_next;
                    borrow <= chain[W];
                    idx    <= idx + 1'b1;
                    if (last) begin
                        D     <= res_next;
                        Bout  <= chain[W];
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUBER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (state == RUN && last)
            ovf <= (a_r[N-1] != b_r[N-1]) & (res_next[N-1] != a_r[N-1]);
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_suber.sv
// Bench for serial_suber: arithmetic/handshake model checked every cycle, plus
// directed literal vectors (N=16/W=4 main instance, N=8/W=8 single-digit instance).
module tb_serial_suber;

    localparam int N = 16;
    localparam int W = 4;
    localparam int K = N / W;
`ifdef SUBER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] A = '0, B = '0;
    logic         Bin = 1'b0;
    logic         busy, done, Bout, ovf;
    logic [N-1:0] D;

    logic         start8 = 1'b0;
    logic [7:0]   A8 = '0, B8 = '0;
    logic         Bin8 = 1'b0;
    logic         busy8, done8, Bout8, ovf8;
    logic [7:0]   D8;

    serial_suber #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
        .busy(busy), .done(done), .D(D), .Bout(Bout), .ovf(ovf)
    );

    serial_suber #(.N(8), .W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .Bin(Bin8),
        .busy(busy8), .done(done8), .D(D8), .Bout(Bout8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // model state: cycles of RUN left, and the currently visible results
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [N-1:0] m_D = '0, p_D = '0;
    logic         m_Bout = 1'b0, p_Bout = 1'b0;
    logic         m_ovf = 1'b0, p_ovf = 1'b0;
    logic [N:0]   wide;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic bi, input logic [N-1:0] exp_d, input logic exp_bout,
                          input logic exp_ovf);
        int n;
        @(negedge clk);
        A = a; B = b; Bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, K + 1);
        chk({nm, "_D"}, D, exp_d);
        chk({nm, "_Bout"}, Bout, exp_bout);
        chk({nm, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        int ndone;

        // behavioural model: acceptance when no RUN cycles remain
        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_left = 0; m_done = 1'b0;
                    m_D = '0; m_Bout = 1'b0; m_ovf = 1'b0;
                end else begin
                    m_done = 1'b0;
                    if (m_left > 0) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_D = p_D; m_Bout = p_Bout; m_ovf = p_ovf; m_done = 1'b1;
                        end
                    end else if (start) begin
                        wide   = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, Bin};
                        p_D    = wide[N-1:0];
                        p_Bout = (int'(A) < int'(B) + int'(Bin));
                        p_ovf  = OVF_EN && (A[N-1] != B[N-1]) && (p_D[N-1] != A[N-1]);
                        m_left = K;
                    end
                end
            end
            forever begin
                @(negedge clk);
                chk("busy", busy, m_left > 0);
                chk("done", done, m_done);
                chk("D", D, m_D);
                chk("Bout", Bout, m_Bout);
                chk("ovf", ovf, m_ovf);
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_D", D, 0);
        rst_n = 1'b1;

        run_op("basic", 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        run_op("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("chain", 16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, OVF_EN);
        run_op("big", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // start held high with alternating operands
        @(negedge clk);
        start = 1'b1; A = 16'h1234; B = 16'h0235; Bin = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (A == 16'h1234) begin A = 16'h0100; B = 16'h0FFF; Bin = 1'b1; end
            else begin A = 16'h1234; B = 16'h0235; Bin = 1'b0; end
        end
        start = 1'b0;
        chk("hold_done_count", ndone, 4);
        repeat (3) @(negedge clk);

        // reset asserted in the 2nd RUN cycle
        @(negedge clk);
        A = 16'hABCD; B = 16'h1111; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_D", D, 0);
        chk("arst_Bout", Bout, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        run_op("post_rst", 16'hABCD, 16'h1111, 1'b0, 16'h9ABC, 1'b0, 1'b0);

        // single-digit instance
        @(negedge clk);
        A8 = 8'h10; B8 = 8'h20; Bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("k1_busy", busy8, 1);
        chk("k1_done_early", done8, 0);
        @(negedge clk);
        chk("k1_done", done8, 1);
        chk("k1_busy_off", busy8, 0);
        chk("k1_D", D8, 8'hF0);
        chk("k1_Bout", Bout8, 1);
        chk("k1_ovf", ovf8, 0);
        @(negedge clk);
        chk("k1_done_pulse", done8, 0);
        chk("k1_D_hold", D8, 8'hF0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
